// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Microcode sequencer for the 8-bit bus computer. It tracks the T-state of
//   the current instruction and decodes (tstate, ir, cf, zf, run, halted) into
//   one control word per clock. The datapath captures on the same rising edge
//   that advances tstate.
//
//   Build option (macro EARLY_END_EN):
//     defined   : each instruction ends right after its last productive step.
//     undefined : every instruction except HLT runs T0..T4. Steps past its
//                 productive length drive the inactive word, and tstate
//                 wraps 4 -> 0.
//
//   Ports:
//     clk     system clock, rising edge
//     clr_    asynchronous active-low reset
//     run     1 = advance, 0 = pause (hold step, inactive word)
//     ir      opcode (upper nibble of IR)
//     cf, zf  carry / zero flags, sampled in T2 only
//     tstate  current T-state 0..4
//     halted  sticky halt status
//     hlt, mi, ri, ro_, ii, io, ai, ao, eo, su, fi, bi, oi, ce, co, j
//             datapath control lines (ro_ is active low)
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int unsigned OPW = 4,
  parameter int unsigned TW  = 3
) (
  input  logic           clk,
  input  logic           clr_,
  input  logic           run,
  input  logic [OPW-1:0] ir,
  input  logic           cf,
  input  logic           zf,
  output logic [TW-1:0]  tstate,
  output logic           halted,
  output logic           hlt,
  output logic           mi,
  output logic           ri,
  output logic           ro_,
  output logic           ii,
  output logic           io,
  output logic           ai,
  output logic           ao,
  output logic           eo,
  output logic           su,
  output logic           fi,
  output logic           bi,
  output logic           oi,
  output logic           ce,
  output logic           co,
  output logic           j
);

  // T-state encodings
  localparam logic [TW-1:0] T0 = TW'(0);
  localparam logic [TW-1:0] T1 = TW'(1);
  localparam logic [TW-1:0] T2 = TW'(2);
  localparam logic [TW-1:0] T3 = TW'(3);
  localparam logic [TW-1:0] T4 = TW'(4);

  // Opcodes; 9..D are undefined and behave as NOP
  localparam logic [OPW-1:0] OP_NOP = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_JC  = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

  // Control word; ro is the active-high sense of ro_
  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic fi;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '0;

  logic [TW-1:0] tstate_q;
  logic [TW-1:0] tstate_d;
  logic          halted_q;
  logic          halted_d;
  logic [TW-1:0] last_step;
  ctrl_word_t    cw;

  // Final step of the current instruction
  always_comb begin
    last_step = T4;
`ifdef EARLY_END_EN
    case (ir)
      OP_LDA, OP_STA:                          last_step = T3;
      OP_ADD, OP_SUB:                          last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ,
      OP_OUT, OP_HLT:                          last_step = T2;
      default:                                 last_step = T1;
    endcase
`endif
  end

  // State register
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      tstate_q <= T0;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: halted freezes everything, run=0 holds the step.
  // The >= compare keeps tstate within 0..4 even if ir changes mid-instruction.
  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    if (!halted_q && run) begin
      if ((ir == OP_HLT) && (tstate_q == T2)) begin
        halted_d = 1'b1;
        tstate_d = T0;
      end else if (tstate_q >= last_step) begin
        tstate_d = T0;
      end else begin
        tstate_d = tstate_q + TW'(1);
      end
    end
  end

  // Control word decode; priority is clr_, then halted, then run
  always_comb begin
    cw = CW_IDLE;
    if (!clr_) begin
      cw.co = 1'b1;
      cw.mi = 1'b1;
    end else if (halted_q) begin
      cw.hlt = 1'b1;
    end else if (run) begin
      case (tstate_q)
        T0: begin
          cw.co = 1'b1;
          cw.mi = 1'b1;
        end
        T1: begin
          cw.ro = 1'b1;
          cw.ii = 1'b1;
          cw.ce = 1'b1;
        end
        T2: begin
          case (ir)
            OP_NOP: ;
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw.io = 1'b1;
              cw.mi = 1'b1;
            end
            OP_LDI: begin
              cw.io = 1'b1;
              cw.ai = 1'b1;
            end
            OP_JMP: begin
              cw.io = 1'b1;
              cw.j  = 1'b1;
            end
            OP_JC: begin
              cw.io = 1'b1;
              cw.j  = cf;
            end
            OP_JZ: begin
              cw.io = 1'b1;
              cw.j  = zf;
            end
            OP_OUT: begin
              cw.ao = 1'b1;
              cw.oi = 1'b1;
            end
            OP_HLT: cw.hlt = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (ir)
            OP_LDA: begin
              cw.ro = 1'b1;
              cw.ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw.ro = 1'b1;
              cw.bi = 1'b1;
            end
            OP_STA: begin
              cw.ao = 1'b1;
              cw.ri = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if ((ir == OP_ADD) || (ir == OP_SUB)) begin
            cw.eo = 1'b1;
            cw.ai = 1'b1;
            cw.fi = 1'b1;
            cw.su = (ir == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = tstate_q;
  assign halted = halted_q;
  assign hlt    = cw.hlt;
  assign mi     = cw.mi;
  assign ri     = cw.ri;
  assign ro_    = ~cw.ro;
  assign ii     = cw.ii;
  assign io     = cw.io;
  assign ai     = cw.ai;
  assign ao     = cw.ao;
  assign eo     = cw.eo;
  assign su     = cw.su;
  assign fi     = cw.fi;
  assign bi     = cw.bi;
  assign oi     = cw.oi;
  assign ce     = cw.ce;
  assign co     = cw.co;
  assign j      = cw.j;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit bus computer.
- Tracks the T-state of each instruction and drives every datapath control line: register load/enable, ALU, RAM, MAR, PC and output.
- Decodes the 4-bit opcode held in the instruction register, plus the carry and zero flags, into one control word per clock.
- Sits between the IR/flags registers and the datapath. It is the sole driver of the control lines when the computer runs.

Parameters:
- OPW, 4, opcode width (upper nibble of IR).
- TW, 3, T-state counter width; must hold values 0..4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_  input  1  asynchronous active-low reset.
- run  input  1  1 = sequencer advances; 0 = pause (hold state).
- ir  input  OPW  opcode from instruction register.
- cf  input  1  carry flag.
- zf  input  1  zero flag.
- tstate  output  TW  current T-state, 0..4.
- halted  output  1  sticky halt status.
- hlt  output  1  halt strobe.
- mi  output  1  MAR in.
- ri  output  1  RAM in (write).
- ro_  output  1  RAM out, active low.
- ii  output  1  IR in.
- io  output  1  IR operand (low nibble) out.
- ai  output  1  A register in.
- ao  output  1  A register out.
- eo  output  1  ALU out.
- su  output  1  ALU subtract.
- fi  output  1  flags in.
- bi  output  1  B register in.
- oi  output  1  output register in.
- ce  output  1  PC count enable.
- co  output  1  PC out.
- j  output  1  PC load (jump).

Behaviour:
- Reset (clr_=0, async): tstate=0, halted=0. Control word immediately shows T0 fetch (co=1, mi=1, all others 0, ro_=1).
- Timing: the control word is a combinational decode of (tstate, ir, cf, zf, run, halted). The datapath captures on the same rising edge that advances tstate.
- Inactive control word: all active-high outputs 0, ro_=1.
- Fetch, common to all opcodes:
  - T0: co, mi.
  - T1: ro_=0, ii, ce.
- Execute, by ir value:
  - 0 NOP: none; length 2.
  - 1 LDA: T2 io, mi; T3 ro_=0, ai; length 4.
  - 2 ADD: T2 io, mi; T3 ro_=0, bi; T4 eo, ai, fi; length 5.
  - 3 SUB: as ADD, with su=1 in T4; length 5.
  - 4 STA: T2 io, mi; T3 ao, ri; length 4.
  - 5 LDI: T2 io, ai; length 3.
  - 6 JMP: T2 io, j; length 3.
  - 7 JC: T2 io, j=cf; length 3 whether taken or not.
  - 8 JZ: T2 io, j=zf; length 3.
  - E OUT: T2 ao, oi; length 3.
  - F HLT: T2 hlt; length 3.
  - 9..D: undefined, treated as NOP.
- cf/zf are sampled combinationally in T2 only.
- Step advance (run=1, halted=0): on the edge ending the last step, tstate goes to 0. Otherwise tstate increments by 1. tstate never exceeds 4.
- HLT: on the edge ending T2, halted is set to 1 and tstate goes to 0.
- While halted=1:
  - tstate is frozen.
  - Control word is inactive except hlt=1.
  - Only clr_ clears halted; run has no effect.
- run=0: tstate is held and the control word is forced inactive (hlt=0), so no datapath register loads. run=1 resumes at the held step with its normal word.
- run changes take effect at the next edge decision; there are no mid-cycle glitch requirements beyond the combinational decode.
- Reset mid-instruction: the instruction is abandoned, tstate=0 and halted=0 at once. Memory/PC contents are not this block's concern.
- Simultaneous events: clr_ overrides everything, then halted, then run.

Optional Feature:
- Macro: EARLY_END_EN.
- Defined: variable instruction lengths as listed above, with tstate returning to 0 right after the last productive step.
- Undefined: every instruction except HLT runs all five T-states. Steps beyond an instruction's listed length output the inactive word, and tstate wraps 4->0. HLT still sets halted at the end of T2.
- The control word at each productive step is identical in both builds.

Test Plan:
- Reset: clr_=0 while tstate=3 -> tstate=0 and halted=0 immediately (before the next clk); co=1, mi=1, ro_=1, all others 0.
- LDA, ir=1, run=1: T0 co,mi -> T1 ro_=0,ii,ce -> T2 io,mi -> T3 ro_=0,ai -> next cycle tstate=0 (EARLY_END_EN). Without the macro, T4 is an inactive word and tstate returns to 0 after T4.
- SUB, ir=3: T3 ro_=0,bi; T4 eo=1, ai=1, fi=1, su=1. ADD (ir=2) at T4 gives su=0.
- JC, ir=7: cf=0 -> T2 io=1, j=0; cf=1 -> T2 io=1, j=1. Either way tstate=0 after T2. JZ (ir=8) gives the same pattern with zf.
- HLT, ir=F: T2 hlt=1. After the edge, halted=1 and tstate=0. For 10 further clocks with run toggling, the word stays hlt=1/inactive. clr_ pulse -> halted=0, T0 word.
- Pause: ADD, run=0 during T3 for 3 clocks -> tstate stays 3 and the word is inactive (ro_=1, bi=0). run=1 -> T3 ro_=0,bi, then T4 eo,ai,fi.
